// File: rtl/spi_frame_rx.sv
// spi_frame_rx: SPI slave frame receiver. SCLK/MOSI/CS are synchronised into clk,
// a fixed-length frame is shifted in MSB first and committed on CS rising.
// Optional CRC-8 check on the last byte: define SPI_FRAME_CRC8_EN.
module spi_frame_rx #(
    parameter int unsigned FRAME_BYTES = 51,
    parameter int unsigned SAMPLE_RISE = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clk_en,
    input  logic                     SCLK,
    input  logic                     MOSI,
    input  logic                     CS,
    output logic [FRAME_BYTES*8-1:0] frame_data,
    output logic                     SPI_WR,
    output logic                     frame_err,
    output logic                     crc_err,
    output logic [15:0]              frame_cnt
);

    localparam int unsigned FRAME_BITS = FRAME_BYTES * 8;
    localparam int unsigned CNT_W      = $clog2(FRAME_BITS + 2);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECV   = 2'd1,
        COMMIT = 2'd2
    } state_e;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic                   sclk_dly_q, sclk_dly_d;
    logic                   cs_dly_q, cs_dly_d;

    state_e                 state_q, state_d;
    logic [FRAME_BITS-1:0]  shift_q, shift_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   ovf_q, ovf_d;
    logic                   fall_pend_q, fall_pend_d;
    logic [FRAME_BITS-1:0]  frame_data_q, frame_data_d;
    logic [15:0]            frame_cnt_q, frame_cnt_d;
    logic                   spi_wr_q, spi_wr_d;
    logic                   frame_err_q, frame_err_d;

    logic sclk_s, mosi_s, cs_s;
    logic samp_edge_c, cs_rise_c, cs_fall_c;

`ifdef SPI_FRAME_CRC8_EN
    localparam int unsigned CRC_BITS = FRAME_BITS - 8;
    logic [7:0] crc_q, crc_d;
    logic       crc_err_q, crc_err_d;

    // One MSB-first step of CRC-8, polynomial 0x07.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
        logic fb;
        fb        = crc[7] ^ bit_in;
        crc8_step = {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction
`endif

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];

    // Edge detection against the delayed copies (delay stage held while clk_en is low).
    assign samp_edge_c = (SAMPLE_RISE != 0) ? (sclk_s & ~sclk_dly_q) : (~sclk_s & sclk_dly_q);
    assign cs_rise_c   = cs_s & ~cs_dly_q;
    assign cs_fall_c   = ~cs_s & cs_dly_q;

    // Synchroniser shift chains run every clk regardless of clk_en.
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], CS};
    end

    // Next-state, datapath and pulse generation.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        ovf_d        = ovf_q;
        fall_pend_d  = fall_pend_q;
        frame_data_d = frame_data_q;
        frame_cnt_d  = frame_cnt_q;
        sclk_dly_d   = sclk_dly_q;
        cs_dly_d     = cs_dly_q;
        spi_wr_d     = 1'b0;
        frame_err_d  = 1'b0;
`ifdef SPI_FRAME_CRC8_EN
        crc_d        = crc_q;
        crc_err_d    = 1'b0;
`endif
        if (clk_en) begin
            sclk_dly_d = sclk_s;
            cs_dly_d   = cs_s;
            case (state_q)
                IDLE: begin
                    // A fall seen during COMMIT is remembered and taken here.
                    if (cs_fall_c || fall_pend_q) begin
                        state_d     = RECV;
                        shift_d     = '0;
                        cnt_d       = '0;
                        ovf_d       = 1'b0;
                        fall_pend_d = 1'b0;
`ifdef SPI_FRAME_CRC8_EN
                        crc_d       = 8'h00;
`endif
                    end
                end
                RECV: begin
                    // CS rise wins over a coincident sampling edge.
                    if (cs_rise_c) begin
                        state_d = COMMIT;
                    end else if (samp_edge_c) begin
                        if (cnt_q > CNT_W'(FRAME_BITS)) begin
                            ovf_d = 1'b1;
                        end else begin
                            shift_d = {shift_q[FRAME_BITS-2:0], mosi_s};
                            cnt_d   = cnt_q + CNT_W'(1);
`ifdef SPI_FRAME_CRC8_EN
                            if (cnt_q < CNT_W'(CRC_BITS)) begin
                                crc_d = crc8_step(crc_q, mosi_s);
                            end
`endif
                        end
                    end
                end
                COMMIT: begin
                    state_d = IDLE;
                    if (cs_fall_c) begin
                        fall_pend_d = 1'b1;
                    end
                    if ((cnt_q != CNT_W'(FRAME_BITS)) || ovf_q) begin
                        frame_err_d = 1'b1;
`ifdef SPI_FRAME_CRC8_EN
                    end else if (crc_q != shift_q[7:0]) begin
                        crc_err_d = 1'b1;
`endif
                    end else begin
                        frame_data_d = shift_q;
                        spi_wr_d     = 1'b1;
                        frame_cnt_d  = frame_cnt_q + 16'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q  <= '0;
            mosi_sync_q  <= '0;
            cs_sync_q    <= '0;
            sclk_dly_q   <= 1'b0;
            cs_dly_q     <= 1'b0;
            state_q      <= IDLE;
            shift_q      <= '0;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
            fall_pend_q  <= 1'b0;
            frame_data_q <= '0;
            frame_cnt_q  <= 16'd0;
            spi_wr_q     <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef SPI_FRAME_CRC8_EN
            crc_q        <= 8'h00;
            crc_err_q    <= 1'b0;
`endif
        end else begin
            sclk_sync_q  <= sclk_sync_d;
            mosi_sync_q  <= mosi_sync_d;
            cs_sync_q    <= cs_sync_d;
            sclk_dly_q   <= sclk_dly_d;
            cs_dly_q     <= cs_dly_d;
            state_q      <= state_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            ovf_q        <= ovf_d;
            fall_pend_q  <= fall_pend_d;
            frame_data_q <= frame_data_d;
            frame_cnt_q  <= frame_cnt_d;
            spi_wr_q     <= spi_wr_d;
            frame_err_q  <= frame_err_d;
`ifdef SPI_FRAME_CRC8_EN
            crc_q        <= crc_d;
            crc_err_q    <= crc_err_d;
`endif
        end
    end

    assign frame_data = frame_data_q;
    assign frame_cnt  = frame_cnt_q;
    assign SPI_WR     = spi_wr_q;
    assign frame_err  = frame_err_q;
`ifdef SPI_FRAME_CRC8_EN
    assign crc_err    = crc_err_q;
`else
    assign crc_err    = 1'b0;
`endif

endmodule

// File: tb/tb_spi_frame_rx.sv
// Testbench for spi_frame_rx: directed sequence with random payloads, checked
// against a byte-level frame model.
module tb_spi_frame_rx;

    localparam int unsigned FRAME_BYTES = 51;
    localparam int unsigned FRAME_BITS  = FRAME_BYTES * 8;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned LAT         = SYNC_STAGES + 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  clk_en;
    logic                  SCLK;
    logic                  MOSI;
    logic                  CS;
    logic [FRAME_BITS-1:0] frame_data;
    logic                  SPI_WR;
    logic                  frame_err;
    logic                  crc_err;
    logic [15:0]           frame_cnt;

    always #5 clk = ~clk;

    spi_frame_rx #(
        .FRAME_BYTES(FRAME_BYTES),
        .SAMPLE_RISE(1),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clk_en    (clk_en),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .CS        (CS),
        .frame_data(frame_data),
        .SPI_WR    (SPI_WR),
        .frame_err (frame_err),
        .crc_err   (crc_err),
        .frame_cnt (frame_cnt)
    );

    int checks = 0;
    int errors = 0;

    bit                    tx_bits[$];
    logic [7:0]            fbytes[FRAME_BYTES];
    logic [FRAME_BITS-1:0] exp_data = '0;
    logic [15:0]           exp_cnt  = 16'd0;

    task automatic check(input string tag, input logic [FRAME_BITS-1:0] obs,
                         input logic [FRAME_BITS-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Byte-wise CRC-8 (poly 0x07, init 0) over all bytes except the last.
    function automatic logic [7:0] crc8_bytes();
        logic [7:0] c = 8'h00;
        for (int i = 0; i < FRAME_BYTES - 1; i++) begin
            c = c ^ fbytes[i];
            for (int b = 0; b < 8; b++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    task automatic set_crc();
`ifdef SPI_FRAME_CRC8_EN
        fbytes[FRAME_BYTES-1] = crc8_bytes();
`endif
    endtask

    task automatic random_bytes();
        for (int i = 0; i < FRAME_BYTES; i++) fbytes[i] = 8'($urandom);
    endtask

    task automatic bytes_to_bits();
        tx_bits.delete();
        for (int i = 0; i < FRAME_BYTES; i++)
            for (int b = 7; b >= 0; b--) tx_bits.push_back(fbytes[i][b]);
    endtask

    // 0 none, 1 good, 2 bit-count error, 3 crc error.
    function automatic int expected_kind();
        if (tx_bits.size() != FRAME_BITS) return 2;
`ifdef SPI_FRAME_CRC8_EN
        if (crc8_bytes() != fbytes[FRAME_BYTES-1]) return 3;
`endif
        return 1;
    endfunction

    function automatic logic [FRAME_BITS-1:0] bits_to_vec();
        logic [FRAME_BITS-1:0] v = '0;
        for (int i = 0; i < FRAME_BITS; i++) v[FRAME_BITS-1-i] = tx_bits[i];
        return v;
    endfunction

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_frame();
        CS   = 1'b0;
        SCLK = 1'b0;
        wait_neg(4);
    endtask

    // SCLK = clk/4, MOSI set with SCLK low and held 2 clk either side of the rise.
    task automatic send_bits(input int from, input int to);
        for (int i = from; i < to; i++) begin
            MOSI = tx_bits[i];
            SCLK = 1'b0;
            wait_neg(2);
            SCLK = 1'b1;
            wait_neg(2);
        end
    endtask

    // Raise CS, watch the pulses, update the model, compare held state.
    task automatic end_frame(input string tag, input int kind, input bit chk_lat);
        int n_wr = 0, n_fe = 0, n_ce = 0, first = 0;
        SCLK = 1'b0;
        wait_neg(2);
        CS = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (SPI_WR === 1'b1)    begin n_wr++; if (first == 0) first = k; end
            if (frame_err === 1'b1) begin n_fe++; if (first == 0) first = k; end
            if (crc_err === 1'b1)   begin n_ce++; if (first == 0) first = k; end
        end
        check($sformatf("%s_spi_wr", tag),    FRAME_BITS'(n_wr), FRAME_BITS'(kind == 1));
        check($sformatf("%s_frame_err", tag), FRAME_BITS'(n_fe), FRAME_BITS'(kind == 2));
        check($sformatf("%s_crc_err", tag),   FRAME_BITS'(n_ce), FRAME_BITS'(kind == 3));
        if (chk_lat && kind != 0) check($sformatf("%s_latency", tag), FRAME_BITS'(first), FRAME_BITS'(LAT));
        if (kind == 1) begin
            exp_data = bits_to_vec();
            exp_cnt  = exp_cnt + 16'd1;
        end
        check($sformatf("%s_data", tag), frame_data, exp_data);
        check($sformatf("%s_cnt", tag),  FRAME_BITS'(frame_cnt), FRAME_BITS'(exp_cnt));
        wait_neg(4);
    endtask

    task automatic run_frame(input string tag);
        start_frame();
        send_bits(0, tx_bits.size());
        end_frame(tag, expected_kind(), 1'b1);
    endtask

    initial begin
        int n_p;
        CS = 1'b1; SCLK = 1'b0; MOSI = 1'b0; clk_en = 1'b1; rst_n = 1'b0;
        wait_neg(5);
        check("rst_data", frame_data, '0);
        check("rst_cnt", FRAME_BITS'(frame_cnt), '0);
        check("rst_pulses", FRAME_BITS'({SPI_WR, frame_err, crc_err}), '0);
        rst_n = 1'b1;
        wait_neg(5);

        // Directed pattern frame.
        for (int i = 0; i < 8; i++) fbytes[i] = 8'h00;
        fbytes[0] = 8'h80;
        fbytes[7] = 8'h01;
        for (int i = 8; i < FRAME_BYTES; i++) fbytes[i] = 8'(i - 7);
        set_crc();
        bytes_to_bits();
        run_frame("pattern");

        // Short and long frames.
        random_bytes(); set_crc(); bytes_to_bits();
        void'(tx_bits.pop_back());
        run_frame("short");
        random_bytes(); set_crc(); bytes_to_bits();
        tx_bits.push_back(1'($urandom));
        run_frame("long");

        // Random good frames.
        for (int f = 0; f < 3; f++) begin
            random_bytes(); set_crc(); bytes_to_bits();
            run_frame($sformatf("rand%0d", f));
        end

        // Reset mid-frame with CS held low, then remaining SCLKs ignored.
        random_bytes(); set_crc(); bytes_to_bits();
        start_frame();
        send_bits(0, 200);
        rst_n = 1'b0;
        wait_neg(3);
        exp_data = '0;
        exp_cnt  = 16'd0;
        check("midrst_data", frame_data, exp_data);
        check("midrst_cnt", FRAME_BITS'(frame_cnt), FRAME_BITS'(exp_cnt));
        rst_n = 1'b1;
        send_bits(200, 260);
        end_frame("midrst_cut", 0, 1'b0);
        random_bytes(); set_crc(); bytes_to_bits();
        run_frame("after_rst");

        // clk_en low for 10 cycles spanning the CS rising edge.
        random_bytes(); set_crc(); bytes_to_bits();
        start_frame();
        send_bits(0, FRAME_BITS);
        SCLK = 1'b0;
        wait_neg(2);
        clk_en = 1'b0;
        n_p = 0;
        wait_neg(3);
        CS = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (SPI_WR || frame_err || crc_err) n_p++;
        end
        check("clken_no_pulse", FRAME_BITS'(n_p), '0);
        clk_en = 1'b1;
        n_p = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (SPI_WR === 1'b1) n_p++;
        end
        check("clken_spi_wr", FRAME_BITS'(n_p), FRAME_BITS'(1));
        exp_data = bits_to_vec();
        exp_cnt  = exp_cnt + 16'd1;
        check("clken_data", frame_data, exp_data);
        check("clken_cnt", FRAME_BITS'(frame_cnt), FRAME_BITS'(exp_cnt));
        wait_neg(4);

`ifdef SPI_FRAME_CRC8_EN
        // Good CRC, corrupted CRC, and count+CRC double failure.
        random_bytes(); set_crc(); bytes_to_bits();
        run_frame("crc_good");
        random_bytes(); set_crc();
        fbytes[FRAME_BYTES-1] = fbytes[FRAME_BYTES-1] ^ 8'h01;
        bytes_to_bits();
        run_frame("crc_bad");
        void'(tx_bits.pop_back());
        run_frame("crc_bad_short");
`endif

        // Counter wrap: preload 0xFFFF, one more good frame wraps to 0.
        @(negedge clk);
        force dut.frame_cnt_q = 16'hFFFF;
        @(posedge clk);
        #1 release dut.frame_cnt_q;
        exp_cnt = 16'hFFFF;
        wait_neg(2);
        random_bytes(); set_crc(); bytes_to_bits();
        run_frame("wrap");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
